// File: rtl/slot_pkg.sv
// slot_pkg: shared state encoding, symbol values and pay-line geometry for slot_payout.
package slot_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, PAY_HI, PAY_LO} state_t;

    localparam logic [2:0] SYM_BLANK   = 3'd0;
    localparam logic [2:0] SYM_JACKPOT = 3'd7;

    localparam logic [2:0] LINE_ROW_A = 3'd0;
    localparam logic [2:0] LINE_ROW_B = 3'd1;
    localparam logic [2:0] LINE_ROW_C = 3'd2;
    localparam logic [2:0] LINE_COL_1 = 3'd3;
    localparam logic [2:0] LINE_COL_2 = 3'd4;
    localparam logic [2:0] LINE_COL_3 = 3'd5;
    localparam logic [2:0] LINE_DIAG  = 3'd6;
    localparam logic [2:0] LINE_ANTI  = 3'd7;

    // Cell index is row-major: a1=0 .. a3=2, b1=3 .. b3=5, c1=6 .. c3=8.
    localparam logic [7:0][2:0][3:0] LINE_MAP = {
        {4'd6, 4'd4, 4'd2},
        {4'd8, 4'd4, 4'd0},
        {4'd8, 4'd5, 4'd2},
        {4'd7, 4'd4, 4'd1},
        {4'd6, 4'd3, 4'd0},
        {4'd8, 4'd7, 4'd6},
        {4'd5, 4'd4, 4'd3},
        {4'd2, 4'd1, 4'd0}
    };

endpackage

// File: rtl/slot_line_eval.sv
// slot_line_eval: combinational scoring of one three-symbol pay line.
module slot_line_eval
    import slot_pkg::*;
#(
    parameter int JACKPOT_PAY = 16
) (
    input  logic [2:0] s0,
    input  logic [2:0] s1,
    input  logic [2:0] s2,
    output logic       win,
    output logic [4:0] pay
);

    localparam logic [4:0] JP = 5'(JACKPOT_PAY);

    always_comb begin
        win = s0 != SYM_BLANK && s0 == s1 && s1 == s2;
        pay = s0 == SYM_JACKPOT ? JP : {2'b00, s0};
    end

endmodule

// File: rtl/slot_payout.sv
// slot_payout: latches the 3x3 grid, scores pay lines one per clock, then pulses the coin hopper.
// Define SLOT_PAYOUT_DIAG_EN to score the two diagonals as well (8 lines instead of 6).
module slot_payout
    import slot_pkg::*;
#(
    parameter int PULSE_W     = 4,
    parameter int JACKPOT_PAY = 16
) (
    input  logic       clk,
    input  logic       clrb,
    input  logic [2:0] slot_a1,
    input  logic [2:0] slot_a2,
    input  logic [2:0] slot_a3,
    input  logic [2:0] slot_b1,
    input  logic [2:0] slot_b2,
    input  logic [2:0] slot_b3,
    input  logic [2:0] slot_c1,
    input  logic [2:0] slot_c2,
    input  logic [2:0] slot_c3,
    input  logic       eval,
    input  logic       hopper_busy,
    output logic       coin_pulse,
    output logic       busy,
    output logic [7:0] credit,
    output logic [7:0] win_lines,
    output logic       jackpot
);

    localparam int CW = PULSE_W > 1 ? $clog2(PULSE_W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PULSE_W - 1);
`ifdef SLOT_PAYOUT_DIAG_EN
    localparam logic [2:0] LAST_LINE = LINE_ANTI;
`else
    localparam logic [2:0] LAST_LINE = LINE_COL_3;
`endif

    state_t state, state_next;
    logic [8:0][2:0] grid;
    logic [2:0] line_idx;
    logic [CW-1:0] cnt;
    logic [2:0] s0, s1, s2;
    logic win;
    logic [4:0] pay;
    logic [7:0] credit_sum;
    logic cnt_done, last;

    assign s0 = grid[LINE_MAP[line_idx][0]];
    assign s1 = grid[LINE_MAP[line_idx][1]];
    assign s2 = grid[LINE_MAP[line_idx][2]];

    slot_line_eval #(.JACKPOT_PAY(JACKPOT_PAY)) u_line (
        .s0(s0),
        .s1(s1),
        .s2(s2),
        .win(win),
        .pay(pay)
    );

    // EVAL always exits through PAY_LO with the gap pre-satisfied, so the
    // first pulse starts one clock after the last line is scored.
    always_comb begin
        credit_sum = credit + (win ? {3'b000, pay} : 8'd0);
        cnt_done = cnt == CNT_MAX;
        last = line_idx == LAST_LINE;
        state_next = state;
        case (state)
            IDLE:    state_next = eval ? EVAL : IDLE;
            EVAL:    state_next = !last ? EVAL : credit_sum == 8'd0 ? IDLE : PAY_LO;
            PAY_HI:  state_next = cnt_done ? PAY_LO : PAY_HI;
            PAY_LO:  state_next = !cnt_done ? PAY_LO : credit == 8'd0 ? IDLE : hopper_busy ? PAY_LO : PAY_HI;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            state <= IDLE;
            grid <= '0;
            line_idx <= '0;
            cnt <= '0;
            coin_pulse <= 1'b0;
            busy <= 1'b0;
            credit <= '0;
            win_lines <= '0;
            jackpot <= 1'b0;
        end else begin
            state <= state_next;
            busy <= state_next != IDLE;
            coin_pulse <= state_next == PAY_HI;
            case (state)
                IDLE: if (eval) begin
                    grid <= {slot_c3, slot_c2, slot_c1, slot_b3, slot_b2, slot_b1, slot_a3, slot_a2, slot_a1};
                    line_idx <= '0;
                    credit <= '0;
                    win_lines <= '0;
                    jackpot <= 1'b0;
                end
                EVAL: begin
                    line_idx <= line_idx + 3'd1;
                    credit <= credit_sum;
                    cnt <= CNT_MAX;
                    if (win) win_lines[line_idx] <= 1'b1;
                    if (win && s0 == SYM_JACKPOT) jackpot <= 1'b1;
                end
                PAY_HI: begin
                    cnt <= cnt_done ? '0 : cnt + 1'b1;
                    if (cnt_done) credit <= credit - 8'd1;
                end
                PAY_LO: cnt <= !cnt_done ? cnt + 1'b1 : state_next == PAY_HI ? '0 : cnt;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_payout.sv
// tb_slot_payout: directed scoreboard bench for slot_payout (PULSE_W=4, JACKPOT_PAY=16).
module tb_slot_payout;

    typedef logic [8:0][2:0] grid_t;
    typedef struct packed {
        logic [7:0] win;
        logic [7:0] credit;
        logic       jp;
    } exp_t;

`ifdef SLOT_PAYOUT_DIAG_EN
    localparam int NL = 8;
`else
    localparam int NL = 6;
`endif
    localparam int PW = 4;

    logic clk = 1'b0;
    logic clrb = 1'b1;
    logic [2:0] slot_a1 = 0, slot_a2 = 0, slot_a3 = 0;
    logic [2:0] slot_b1 = 0, slot_b2 = 0, slot_b3 = 0;
    logic [2:0] slot_c1 = 0, slot_c2 = 0, slot_c3 = 0;
    logic eval = 1'b0;
    logic hopper_busy = 1'b0;
    logic coin_pulse, busy, jackpot;
    logic [7:0] credit, win_lines;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    int cells [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    slot_payout #(.PULSE_W(PW), .JACKPOT_PAY(16)) dut (
        .clk(clk), .clrb(clrb),
        .slot_a1(slot_a1), .slot_a2(slot_a2), .slot_a3(slot_a3),
        .slot_b1(slot_b1), .slot_b2(slot_b2), .slot_b3(slot_b3),
        .slot_c1(slot_c1), .slot_c2(slot_c2), .slot_c3(slot_c3),
        .eval(eval), .hopper_busy(hopper_busy),
        .coin_pulse(coin_pulse), .busy(busy), .credit(credit),
        .win_lines(win_lines), .jackpot(jackpot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic grid_t mk(int a1, int a2, int a3, int b1, int b2, int b3, int c1, int c2, int c3);
        return {3'(c3), 3'(c2), 3'(c1), 3'(b3), 3'(b2), 3'(b1), 3'(a3), 3'(a2), 3'(a1)};
    endfunction

    function automatic exp_t model(grid_t g);
        exp_t e;
        e = '0;
        for (int l = 0; l < NL; l++) begin
            logic [2:0] x, y, z;
            x = g[cells[l][0]];
            y = g[cells[l][1]];
            z = g[cells[l][2]];
            if (x != 0 && x == y && y == z) begin
                e.win[l] = 1'b1;
                e.credit += (x == 3'd7) ? 8'd16 : 8'(x);
                if (x == 3'd7) e.jp = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic set_grid(input grid_t g);
        {slot_c3, slot_c2, slot_c1, slot_b3, slot_b2, slot_b1, slot_a3, slot_a2, slot_a1} = g;
    endtask

    task automatic start_eval(input grid_t g);
        @(negedge clk);
        set_grid(g);
        eval = 1'b1;
        sb.push_back(model(g));
        @(negedge clk);
        eval = 1'b0;
        set_grid(mk(1,2,3,4,5,6,7,1,2));
    endtask

    task automatic compare_sb();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            chk("win_lines", win_lines, e.win);
            chk("credit", credit, e.credit);
            chk("jackpot", jackpot, e.jp);
        end
    endtask

    // Walks negedges from the first one after the eval edge until busy drops.
    task automatic run_pay(input int hb_until, input int eval2_at, input grid_t g2, input int abort_at,
                           output int busy_clks, output int rises, output int highs, output int first_hi);
        logic prev;
        logic [7:0] cred_hold;
        bit done;
        prev = 1'b0;
        cred_hold = '0;
        done = 0;
        busy_clks = 0;
        rises = 0;
        highs = 0;
        first_hi = -1;
        for (int i = 1; i <= 4000 && !done; i++) begin
            if (i == NL + 1) compare_sb();
            if (i == hb_until) hopper_busy = 1'b0;
            if (i == eval2_at) begin
                cred_hold = credit;
                set_grid(g2);
                eval = 1'b1;
            end
            if (i == eval2_at + 1) begin
                eval = 1'b0;
                chk("ignored_eval_credit", credit, cred_hold);
                chk("ignored_eval_no_pulse", coin_pulse, 0);
            end
            if (abort_at != 0 && i == abort_at) begin
                chk("pre_abort_pulse", coin_pulse, 1);
                #2 clrb = 1'b0;
                #1;
                chk("abort_coin_pulse", coin_pulse, 0);
                chk("abort_busy", busy, 0);
                chk("abort_credit", credit, 0);
                chk("abort_win_lines", win_lines, 0);
                chk("abort_jackpot", jackpot, 0);
                @(negedge clk);
                clrb = 1'b1;
                done = 1;
            end else if (!busy) begin
                done = 1;
            end else begin
                busy_clks++;
                if (coin_pulse) begin
                    highs++;
                    if (!prev) begin
                        rises++;
                        if (first_hi < 0) first_hi = i;
                    end
                end
                prev = coin_pulse;
                @(negedge clk);
            end
        end
        if (!done) chk("pay_timeout_busy", busy, 0);
    endtask

    task automatic do_case(input string tag, input grid_t g);
        int bc, r, h, f, n;
        n = int'(model(g).credit);
        start_eval(g);
        run_pay(-1, -10, '0, 0, bc, r, h, f);
        chk({tag, "_pulses"}, r, n);
        chk({tag, "_high_clks"}, h, PW * n);
        chk({tag, "_busy_clks"}, bc, n == 0 ? NL : NL + 1 + 2 * PW * n);
        if (n > 0) chk({tag, "_first_pulse"}, f, NL + 2);
        chk({tag, "_end_credit"}, credit, 0);
    endtask

    initial begin
        int bc, r, h, f;
        #2 clrb = 1'b0;
        #1;
        chk("rst_coin_pulse", coin_pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_credit", credit, 0);
        chk("rst_win_lines", win_lines, 0);
        chk("rst_jackpot", jackpot, 0);
        repeat (2) @(negedge clk);
        clrb = 1'b1;

        do_case("row_a3", mk(3,3,3, 1,2,4, 5,6,1));
        do_case("all7", mk(7,7,7, 7,7,7, 7,7,7));
        do_case("all0", mk(0,0,0, 0,0,0, 0,0,0));
        do_case("diag_col2", mk(5,5,1, 2,5,3, 4,5,5));

        hopper_busy = 1'b1;
        start_eval(mk(2,2,2, 1,3,4, 5,6,1));
        run_pay(NL + 21, NL + 5, mk(7,7,7, 7,7,7, 7,7,7), 0, bc, r, h, f);
        chk("hold_pulses", r, 2);
        chk("hold_high_clks", h, 2 * PW);
        chk("hold_first_pulse", f, NL + 22);
        chk("hold_busy_clks", bc, NL + 21 + 2 * PW * 2);
        chk("hold_scoreboard_drained", 32'(sb.size()), 0);

        start_eval(mk(1,2,3, 5,5,5, 4,6,1));
        run_pay(-1, -10, '0, NL + 4, bc, r, h, f);
        chk("abort_first_pulse", f, NL + 2);

        do_case("after_abort", mk(3,3,3, 1,2,4, 5,6,1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slot_payout.md
# slot_payout

Downstream payout stage for `slotmachine`. It latches the settled 3×3 symbol grid when told to evaluate, and scores 8 pay lines sequentially (6 without diagonals). It then dispenses the won credit as a train of hopper coin pulses under a hopper busy/stall handshake. It sits between `slotmachine`'s `slot_*` outputs and the physical coin hopper driver.

## Interface
Parameters:
- `PULSE_W`, 4: coin pulse high width and minimum low gap, in clocks (≥1).
- `JACKPOT_PAY`, 16: credits paid by a line of symbol 7.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `clrb`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `slot_a1`…`slot_c3`, input, 3 each: grid symbols. Row letter a/b/c, column 1/2/3. 0 = blank.
- `eval`, input, 1: one-cycle request to score the current grid.
- `hopper_busy`, input, 1: hopper cannot accept a new pulse.
- `coin_pulse`, output, 1: one coin per high phase.
- `busy`, output, 1: block is not in IDLE.
- `credit`, output, 8: coins still owed.
- `win_lines`, output, 8: mask of winning lines from the last evaluation.
- `jackpot`, output, 1: last evaluation contained a symbol-7 line.

## Operation
- States: IDLE, EVAL, PAY_HI, PAY_LO.
- **IDLE.** When `eval`=1 at an edge:
  - latch all nine symbols into a grid register;
  - clear `win_lines`, `jackpot` and the line index;
  - go to EVAL.
- `eval` in any other state is ignored. No queueing.
- **Line bits:**
  - 0 = row a, 1 = row b, 2 = row c;
  - 3 = column 1, 4 = column 2, 5 = column 3;
  - 6 = a1-b2-c3, 7 = a3-b2-c1.
- A line wins iff all three latched symbols are equal and nonzero.
- Line pay: symbol value 1–6 pays that value; symbol 7 pays `JACKPOT_PAY`.
- **EVAL.** One line per clock. Winning lines set their `win_lines` bit and add their pay into `credit`. A symbol-7 win also sets `jackpot`.
- Maximum total is 8 × 16 = 128, so `credit` never overflows.
- After the last line:
  - `credit` > 0 → go to PAY_HI if `hopper_busy`=0, otherwise stay in a PAY_LO wait;
  - `credit` = 0 → go to IDLE.
- **PAY_HI.** `coin_pulse`=1 for `PULSE_W` clocks. Decrement `credit` on the last high clock, then go to PAY_LO.
- **PAY_LO.** `coin_pulse`=0 for at least `PULSE_W` clocks. Then:
  - `credit` = 0 → IDLE;
  - otherwise wait until `hopper_busy`=0, then go to PAY_HI.
- `hopper_busy` rising during PAY_HI does not truncate the pulse.
- Grid inputs changing after the latch have no effect.

## Timing
- Reset values: state IDLE; `coin_pulse`, `busy`, `jackpot` = 0; `credit`, `win_lines`, grid, counters = 0.
- `clrb` low mid-evaluation or mid-pay aborts immediately. Owed credit is lost.
- `busy` is registered. It rises on the edge that samples `eval` and falls on the edge that enters IDLE.
- Latency, with the eval edge as E:
  - line k is scored on edge E+1+k;
  - final `win_lines`, `credit` and `jackpot` are valid after E+8 (E+6 without diagonals);
  - the first `coin_pulse` rises on E+9 when `hopper_busy`=0.
- Pulse train: period 2×`PULSE_W` while the hopper is idle. N coins need N×2×`PULSE_W` clocks.
- All outputs are registered. No combinational input→output path.

## Configuration
- `SLOT_PAYOUT_DIAG_EN` defined:
  - 8 lines scored;
  - EVAL takes 8 clocks.
- `SLOT_PAYOUT_DIAG_EN` undefined:
  - only lines 0–5 are scored;
  - EVAL takes 6 clocks;
  - `win_lines[7:6]` are tied to 0.

## Structure
- **Package `slot_pkg`:**
  - state enum;
  - `SYM_BLANK`=0, `SYM_JACKPOT`=7;
  - line index constants 0–7;
  - the line-to-cell mapping.
- **Sub-module `slot_line_eval`:** combinational. Takes three 3-bit symbols plus `JACKPOT_PAY` and outputs `win` and a 5-bit `pay`. Instantiated once and muxed by line index.

## Test plan
- Row a = 3,3,3, all other cells distinct, `eval` → `win_lines`=8'h01, `credit`=3, then exactly 3 `coin_pulse` highs of 4 clocks each; `busy` drops after the last gap.
- All cells = 7 → `win_lines`=8'hFF, `jackpot`=1, `credit`=128, 128 pulses. Without the macro: `win_lines`=8'h3F, `credit`=96.
- All cells = 0 → `win_lines`=0, `credit`=0, no pulse, `busy` high for exactly 8 clocks.
- Diagonal a1-b2-c3 = 5, column 2 = 5 (b2 shared) → `win_lines`=8'h50, `credit`=10.
- `hopper_busy` held high for 20 clocks at the start of PAY → no pulse until it drops; second `eval` during PAY ignored; `credit` unchanged.
- `clrb` pulsed low mid-pay with `credit`=5 → all outputs 0 immediately; the next `eval` works normally.
